// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encodings,
// reset PC default, NOP encoding and address alignment helper.
package instruction_fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_STALLED = 2'd1,
        S_DISCARD = 2'd2
    } if_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_skid.sv
// One-entry skid buffer that parks a fetched instruction while decode stalls.
// Clear wins over load so a redirect always empties the entry.
module fetch_skid
    import instruction_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic        pop,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc4
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc4   <= 32'h0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc4   <= load_pc4;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID register, skid buffer for
// decode back-pressure and squashing of responses after a redirect.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_FETCH   | requesting the word at pc; response goes to IF/ID or skid
// S_STALLED | skid holds the word fetched while decode stalled; no request
// S_DISCARD | a redirect arrived mid-request; drop that response, then pend_pc
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    input  logic             id_stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             ifid_valid,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc4,
    output logic [CNT_W-1:0] fetch_count
);

    if_state_t        state, state_n;
    logic [31:0]      pc, pc_n;
    logic [31:0]      pend_pc, pend_pc_n;
    logic             ifid_valid_n;
    logic [31:0]      ifid_instr_n;
    logic [31:0]      ifid_pc4_n;
    logic [CNT_W-1:0] count_n;

    logic             skid_load, skid_clear, skid_pop;
    logic             skid_valid;
    logic [31:0]      skid_instr, skid_pc4;

    logic [31:0]      redirect_tgt;
    logic [31:0]      pc_plus4;

    assign redirect_tgt = align_pc(redirect_pc);
    assign pc_plus4     = pc + PC_STEP;

    fetch_skid u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .clear      (skid_clear),
        .pop        (skid_pop),
        .load_instr (imem_rdata),
        .load_pc4   (pc_plus4),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc4        (skid_pc4)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= align_pc(RESET_PC);
            pend_pc     <= 32'h0;
            ifid_valid  <= 1'b0;
            ifid_instr  <= NOP_INSTR;
            ifid_pc4    <= 32'h0;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pend_pc     <= pend_pc_n;
            ifid_valid  <= ifid_valid_n;
            ifid_instr  <= ifid_instr_n;
            ifid_pc4    <= ifid_pc4_n;
            fetch_count <= count_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pend_pc_n    = pend_pc;
        ifid_valid_n = ifid_valid;
        ifid_instr_n = ifid_instr;
        ifid_pc4_n   = ifid_pc4;
        count_n      = fetch_count;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        skid_pop     = 1'b0;
        imem_req     = (state != S_STALLED);
        imem_addr    = pc;

        // A redirect always leaves a bubble in IF/ID and empties the skid.
        if (redirect_valid) begin
            ifid_valid_n = 1'b0;
            ifid_instr_n = NOP_INSTR;
            skid_clear   = 1'b1;
        end

        case (state)
            S_FETCH: begin
                if (redirect_valid) begin
                    if (imem_ready) begin
                        pc_n = redirect_tgt;
                    end else begin
                        pend_pc_n = redirect_tgt;
                        state_n   = S_DISCARD;
                    end
                end else if (imem_ready) begin
                    pc_n = pc_plus4;
                    if (id_stall) begin
                        skid_load = 1'b1;
                        state_n   = S_STALLED;
                    end else begin
                        ifid_valid_n = 1'b1;
                        ifid_instr_n = imem_rdata;
                        ifid_pc4_n   = pc_plus4;
                        count_n      = fetch_count + CNT_W'(1);
                    end
                end else if (!id_stall) begin
                    ifid_valid_n = 1'b0;
                    ifid_instr_n = NOP_INSTR;
                end
            end

            S_STALLED: begin
                if (redirect_valid) begin
                    pc_n    = redirect_tgt;
                    state_n = S_FETCH;
                end else if (!id_stall) begin
                    ifid_valid_n = skid_valid;
                    ifid_instr_n = skid_instr;
                    ifid_pc4_n   = skid_pc4;
                    skid_pop     = 1'b1;
                    count_n      = fetch_count + CNT_W'(1);
                    state_n      = S_FETCH;
                end
            end

            S_DISCARD: begin
                ifid_valid_n = 1'b0;
                ifid_instr_n = NOP_INSTR;
                if (imem_ready) begin
                    pc_n    = redirect_valid ? redirect_tgt : pend_pc;
                    state_n = S_FETCH;
                end else if (redirect_valid) begin
                    pend_pc_n = redirect_tgt;
                end
            end

            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

endmodule
